// File: rtl/counter_run_ctrl.sv
// Run sequencer for the pipelined up-counter: issues load/enable strobes,
// shadows the count, and handles pause, abort and auto-reload passes.
module counter_run_ctrl #(
    parameter int WIDTH  = 7,
    parameter int DIV_W  = 4,
    parameter int WRAP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              pause,
    input  logic              abort,
    input  logic [WIDTH-1:0]  cfg_start_val,
    input  logic [WIDTH-1:0]  cfg_end_val,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic              cfg_auto_reload,
    output logic              cnt_load,
    output logic [WIDTH-1:0]  cnt_load_val,
    output logic              cnt_en,
    output logic [WIDTH-1:0]  cur_cnt,
    output logic              busy,
    output logic              done,
    output logic [WRAP_W-1:0] run_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_HOLD,
        ST_DONE
    } state_t;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   start_val_reg, start_val_next;
    logic [WIDTH-1:0]   end_val_reg, end_val_next;
    logic [DIV_W-1:0]   div_reg, div_next;
    logic               auto_reg, auto_next;
    logic [DIV_W-1:0]   presc_reg, presc_next;
    logic [WIDTH-1:0]   cur_cnt_reg, cur_cnt_next;
    logic [WRAP_W-1:0]  run_cnt_reg, run_cnt_next;
    logic               cnt_load_reg, cnt_load_next;
    logic               cnt_en_reg, cnt_en_next;
    logic               done_reg, done_next;
    logic               busy_reg, busy_next;
    logic [WIDTH-1:0]   cnt_inc;

    assign cnt_inc = cur_cnt_reg + WIDTH'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            start_val_reg <= '0;
            end_val_reg   <= '0;
            div_reg       <= '0;
            auto_reg      <= 1'b0;
            presc_reg     <= '0;
            cur_cnt_reg   <= '0;
            run_cnt_reg   <= '0;
            cnt_load_reg  <= 1'b0;
            cnt_en_reg    <= 1'b0;
            done_reg      <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            start_val_reg <= start_val_next;
            end_val_reg   <= end_val_next;
            div_reg       <= div_next;
            auto_reg      <= auto_next;
            presc_reg     <= presc_next;
            cur_cnt_reg   <= cur_cnt_next;
            run_cnt_reg   <= run_cnt_next;
            cnt_load_reg  <= cnt_load_next;
            cnt_en_reg    <= cnt_en_next;
            done_reg      <= done_next;
            busy_reg      <= busy_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        start_val_next = start_val_reg;
        end_val_next   = end_val_reg;
        div_next       = div_reg;
        auto_next      = auto_reg;
        presc_next     = presc_reg;
        cur_cnt_next   = cur_cnt_reg;
        run_cnt_next   = run_cnt_reg;
        cnt_load_next  = 1'b0;
        cnt_en_next    = 1'b0;
        done_next      = 1'b0;
        busy_next      = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    start_val_next = cfg_start_val;
                    end_val_next   = cfg_end_val;
                    div_next       = cfg_div;
                    auto_next      = cfg_auto_reload;
                    run_cnt_next   = '0;
                    state_next     = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cnt_load_next = 1'b1;
                cur_cnt_next  = start_val_reg;
                presc_next    = '0;
                state_next    = (start_val_reg == end_val_reg) ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                if (pause) begin
                    state_next = ST_HOLD;
                end else if (presc_reg == div_reg) begin
                    cnt_en_next  = 1'b1;
                    presc_next   = '0;
                    cur_cnt_next = cnt_inc;
                    if (cnt_inc == end_val_reg) begin
                        if (auto_reg) begin
                            if (!(&run_cnt_reg)) begin
                                run_cnt_next = run_cnt_reg + WRAP_W'(1);
                            end
                            state_next = ST_LOAD;
                        end else begin
                            state_next = ST_DONE;
                        end
                    end
                end else begin
                    presc_next = presc_reg + DIV_W'(1);
                end
            end
            ST_HOLD: begin
                // prescaler is untouched here so the tick phase survives the pause
                if (!pause) begin
                    state_next = ST_RUN;
                end
            end
            ST_DONE: begin
                done_next  = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // abort outranks everything else: drop the strobes, keep the counts
        if (abort && (state_reg != ST_IDLE)) begin
            state_next    = ST_IDLE;
            cnt_load_next = 1'b0;
            cnt_en_next   = 1'b0;
            done_next     = 1'b0;
            cur_cnt_next  = cur_cnt_reg;
            run_cnt_next  = run_cnt_reg;
            presc_next    = presc_reg;
        end

        busy_next = (state_next == ST_LOAD) || (state_next == ST_RUN) ||
                    (state_next == ST_HOLD);
    end

    assign cnt_load     = cnt_load_reg;
    assign cnt_load_val = start_val_reg;
    assign cnt_en       = cnt_en_reg;
    assign cur_cnt      = cur_cnt_reg;
    assign busy         = busy_reg;
    assign done         = done_reg;
    assign run_cnt      = run_cnt_reg;

endmodule

// File: tb/tb_counter_run_ctrl.sv
// Scoreboard bench: each run's event schedule is derived arithmetically from
// start/end/div, shifted for pause bursts and truncated at the abort edge.
module tb_counter_run_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, pause, abort, cfg_auto_reload;
    logic [6:0] cfg_start_val, cfg_end_val;
    logic [3:0] cfg_div;
    logic       cnt_load, cnt_en, busy, done;
    logic [6:0] cnt_load_val, cur_cnt;
    logic [7:0] run_cnt;

    counter_run_ctrl #(.WIDTH(7), .DIV_W(4), .WRAP_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .abort(abort),
        .cfg_start_val(cfg_start_val), .cfg_end_val(cfg_end_val),
        .cfg_div(cfg_div), .cfg_auto_reload(cfg_auto_reload),
        .cnt_load(cnt_load), .cnt_load_val(cnt_load_val), .cnt_en(cnt_en),
        .cur_cnt(cur_cnt), .busy(busy), .done(done), .run_cnt(run_cnt)
    );

    always #5 clk = ~clk;

    // kind: 0 = load, 1 = enable tick, 2 = done; edge_n = clock edge after which it is visible
    typedef struct {
        int edge_n;
        int kind;
        int val;
        bit term;
    } ev_t;

    ev_t exp_q[$];
    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    bit  mon_en = 1'b0;
    int  prev_cur = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic ev_t mk(input int ed, input int kd, input int v, input bit t);
        ev_t ev;
        ev.edge_n = ed;
        ev.kind   = kd;
        ev.val    = v;
        ev.term   = t;
        return ev;
    endfunction

    // monitor: pops one expected event per observed strobe
    always @(negedge clk) begin
        ev_t ev;
        int  k;
        if (mon_en && !rst) begin
            if (cnt_load || cnt_en || done) begin
                k = cnt_load ? 0 : (cnt_en ? 1 : 2);
                if (exp_q.size() == 0) begin
                    chk("unexpected_event_kind", k, -1);
                end else begin
                    ev = exp_q.pop_front();
                    chk("event_kind", k, ev.kind);
                    chk("event_cycle", cyc, ev.edge_n);
                    chk("event_cur_cnt", int'(cur_cnt), ev.val);
                    if (k == 0) chk("load_val", int'(cnt_load_val), ev.val);
                    chk("strobe_onehot", int'(cnt_load) + int'(cnt_en) + int'(done), 1);
                end
            end else if (exp_q.size() > 0 && exp_q[0].edge_n <= cyc) begin
                ev = exp_q.pop_front();
                chk("missing_event_kind", -1, ev.kind);
            end
        end
    end

    task automatic run(input int s, input int e, input int d, input bit ar,
                       input int passes, input int pk_in, input int pofs, input int aofs);
        ev_t sch[$];
        int  T, N, L, A, E, pk, np, done_edge, last_busy, exp_cur, exp_rc, terms;
        @(negedge clk);
        T  = cyc + 1;
        N  = (e - s) & 127;
        L  = T + 1;
        np = 0;
        A  = 1 << 30;
        pk = pk_in;
        if (N == 0 || (ar && passes == 0)) pk = 0;
        E  = T + 2 + pofs;
        done_edge = 1 << 30;

        forever begin
            sch.push_back(mk(L, 0, s, 1'b0));
            if (ar && N > 0 && np == passes) begin
                A = L + 1;
                break;
            end
            for (int k = 1; k <= N; k++)
                sch.push_back(mk(L + k * (d + 1), 1, (s + k) & 127, k == N));
            if (N == 0 || !ar) begin
                sch.push_back(mk(L + N * (d + 1) + 1, 2, e, 1'b0));
                break;
            end
            L  = L + N * (d + 1) + 1;
            np = np + 1;
        end

        // a pause burst of pk cycles entered from RUN delays everything later by pk+1
        if (pk > 0) begin
            foreach (sch[i]) if (sch[i].edge_n >= E) sch[i].edge_n += pk + 1;
            if (A != (1 << 30) && A >= E) A += pk + 1;
        end
        foreach (sch[i]) if (sch[i].kind == 2) done_edge = sch[i].edge_n;
        if (!(ar && N > 0) && aofs >= 0 && T + 1 + aofs <= done_edge) A = T + 1 + aofs;
        last_busy = (A != (1 << 30)) ? A : done_edge;

        exp_cur = prev_cur;
        terms   = 0;
        foreach (sch[i]) begin
            if (sch[i].edge_n < A) begin
                exp_q.push_back(sch[i]);
                if (sch[i].kind != 2) exp_cur = sch[i].val;
                if (sch[i].term) terms++;
            end
        end
        exp_rc = ar ? ((terms > 255) ? 255 : terms) : 0;

        start = 1'b1; cfg_start_val = 7'(s); cfg_end_val = 7'(e);
        cfg_div = 4'(d); cfg_auto_reload = ar; pause = 1'b0; abort = 1'b0;
        for (int x = T + 1; x <= last_busy + 1; x++) begin
            @(negedge clk);
            if (x == T + 1) chk("busy_after_start", int'(busy), 1);
            start           = (x <= last_busy) ? 1'($urandom_range(0, 1)) : 1'b0;
            cfg_start_val   = 7'($urandom);
            cfg_end_val     = 7'($urandom);
            cfg_div         = 4'($urandom);
            cfg_auto_reload = 1'($urandom);
            pause           = (pk > 0 && x >= E && x < E + pk);
            abort           = (x == A);
        end
        @(negedge clk);
        start = 1'b0; pause = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        chk("busy_end", int'(busy), 0);
        chk("final_cur_cnt", int'(cur_cnt), exp_cur);
        chk("final_run_cnt", int'(run_cnt), exp_rc);
        $display("run s=%0d e=%0d div=%0d auto=%0d passes=%0d pause=%0d abort_edge_ofs=%0d cur=%0d run_cnt=%0d",
                 s, e, d, ar, passes, pk, (A == (1 << 30)) ? -1 : A - T, cur_cnt, run_cnt);
        exp_q.delete();
        prev_cur = exp_cur;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, n, d, pk, pofs, aofs, passes;
        bit ar;
        rst = 1'b1; start = 1'b0; pause = 1'b0; abort = 1'b0;
        cfg_start_val = '0; cfg_end_val = '0; cfg_div = '0; cfg_auto_reload = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cnt_load", int'(cnt_load), 0);
        chk("rst_cnt_load_val", int'(cnt_load_val), 0);
        chk("rst_cnt_en", int'(cnt_en), 0);
        chk("rst_cur_cnt", int'(cur_cnt), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_run_cnt", int'(run_cnt), 0);
        rst = 1'b0;
        mon_en = 1'b1;

        run(5, 8, 0, 1'b0, 0, 0, 0, -1);
        run(0, 3, 3, 1'b0, 0, 0, 0, -1);
        run(0, 10, 3, 1'b0, 0, 6, 5, -1);
        run(126, 2, 0, 1'b0, 0, 0, 0, -1);
        run(1, 3, 0, 1'b1, 3, 0, 0, -1);
        run(1, 5, 1, 1'b1, 2, 4, 2, -1);
        run(9, 9, 2, 1'b0, 0, 0, 0, -1);
        run(9, 9, 0, 1'b1, 2, 0, 0, -1);
        run(3, 5, 0, 1'b0, 0, 0, 0, 3);
        run(20, 25, 1, 1'b0, 0, 0, 0, 0);
        run(0, 1, 0, 1'b1, 260, 0, 0, -1);

        for (int i = 0; i < 40; i++) begin
            s      = $urandom_range(0, 127);
            n      = $urandom_range(0, 12);
            d      = $urandom_range(0, 3);
            ar     = ($urandom_range(0, 9) == 0);
            passes = $urandom_range(0, 3);
            pk     = ($urandom_range(0, 9) < 3) ? $urandom_range(1, 5) : 0;
            pofs   = (n > 0) ? $urandom_range(0, n * (d + 1) - 1) : 0;
            aofs   = ($urandom_range(0, 4) == 0) ? $urandom_range(0, n * (d + 1) + 3) : -1;
            run(s, (s + n) & 127, d, ar, passes, pk, pofs, aofs);
        end

        // reset in the middle of a run
        mon_en = 1'b0;
        @(negedge clk);
        start = 1'b1; cfg_start_val = 7'd0; cfg_end_val = 7'd20; cfg_div = 4'd1;
        cfg_auto_reload = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        chk("busy_before_rst", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_cnt_load", int'(cnt_load), 0);
        chk("midrst_cnt_load_val", int'(cnt_load_val), 0);
        chk("midrst_cnt_en", int'(cnt_en), 0);
        chk("midrst_cur_cnt", int'(cur_cnt), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_run_cnt", int'(run_cnt), 0);
        $display("mid-run reset: cur=%0d busy=%0d", cur_cnt, busy);
        exp_q.delete();
        prev_cur = 0;
        mon_en = 1'b1;
        run(7, 10, 0, 1'b0, 0, 0, 0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
